apb_master_bridge: RTL and testbench

//  Upstream APB requester for the UART subsystem top. Converts a valid/ready command stream
//  (host/CPU side) into single APB transfers on p_sel/p_en/p_wr/p_addr/pw_data. Returns

---
 rtl/apb_master_bridge.sv | 144 ++++++++++++++
 tb/tb_apb_master_bridge.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB requester: valid/ready command in, valid/ready response out,
// with word-alignment checking and a p_ready watchdog so a hung slave cannot stall the host.
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              p_sel,
  output logic              p_en,
  output logic              p_wr,
  output logic [ADDR_W-1:0] p_addr,
  output logic [DATA_W-1:0] pw_data,
  input  logic              p_ready,
  input  logic [DATA_W-1:0] pr_data,
  input  logic              pslverr
);

  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX   = '1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t            r_state;
  logic              r_cmd_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_rsp_timeout;
  logic              r_p_sel;
  logic              r_p_en;
  logic              r_p_wr;
  logic [ADDR_W-1:0] r_p_addr;
  logic [DATA_W-1:0] r_pw_data;
  logic [WD_W-1:0]   r_wd;

  logic [WD_W-1:0]   w_wd_inc;
  logic              w_expire;

  // Saturating increment: with the watchdog disabled the count must still never wrap.
  assign w_wd_inc = (r_wd == WD_MAX) ? r_wd : r_wd + 1'b1;
  assign w_expire = (TIMEOUT != 0) && (w_wd_inc == WD_LIMIT);

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      r_state       <= S_IDLE;
      r_cmd_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_p_sel       <= 1'b0;
      r_p_en        <= 1'b0;
      r_p_wr        <= 1'b0;
      r_p_addr      <= '0;
      r_pw_data     <= '0;
      r_wd          <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            if (cmd_addr[1:0] == 2'b00) begin
              r_state   <= S_SETUP;
              r_p_sel   <= 1'b1;
              r_p_en    <= 1'b0;
              r_p_wr    <= cmd_wr;
              r_p_addr  <= cmd_addr;
              r_pw_data <= cmd_wdata;
              r_wd      <= '0;
            end else begin
              // Misaligned: answer immediately, APB bus stays untouched.
              r_state       <= S_RESP;
              r_rsp_valid   <= 1'b1;
              r_rsp_err     <= 1'b1;
              r_rsp_timeout <= 1'b0;
              r_rsp_rdata   <= '0;
            end
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        S_SETUP: begin
          r_p_en  <= 1'b1;
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (p_ready) begin
            r_p_sel       <= 1'b0;
            r_p_en        <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_err     <= pslverr;
            r_rsp_timeout <= 1'b0;
            r_rsp_rdata   <= (!r_p_wr && !pslverr) ? pr_data : '0;
            r_state       <= S_RESP;
          end else if (w_expire) begin
            r_wd          <= w_wd_inc;
            r_p_sel       <= 1'b0;
            r_p_en        <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_rdata   <= '0;
            r_state       <= S_RESP;
          end else begin
            r_wd <= w_wd_inc;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;
  assign p_sel       = r_p_sel;
  assign p_en        = r_p_en;
  assign p_wr        = r_p_wr;
  assign p_addr      = r_p_addr;
  assign pw_data     = r_pw_data;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge (TIMEOUT=16): normal, wait-state, slave error,
// watchdog, misaligned, back-pressure/back-to-back and mid-transfer reset scenarios.
module tb_apb_master_bridge;

  logic        pclk = 1'b0;
  logic        prst;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic        p_sel, p_en, p_wr;
  logic [31:0] p_addr, pw_data;
  logic        p_ready;
  logic [31:0] pr_data;
  logic        pslverr;

  int checks = 0;
  int errors = 0;

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .pclk(pclk), .prst(prst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .p_sel(p_sel), .p_en(p_en), .p_wr(p_wr), .p_addr(p_addr), .pw_data(pw_data),
    .p_ready(p_ready), .pr_data(pr_data), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata;
  endtask

  task automatic test_reset();
    prst = 1'b0; cmd_valid = 0; cmd_wr = 0; cmd_addr = 0; cmd_wdata = 0;
    rsp_ready = 0; p_ready = 0; pr_data = 0; pslverr = 0;
    tick(); tick();
    checks++; if ({cmd_ready, rsp_valid, rsp_err, rsp_timeout, p_sel, p_en, p_wr} !== 7'b0)
      begin errors++; $display("FAIL reset_ctrl got=%b exp=0000000", {cmd_ready, rsp_valid, rsp_err, rsp_timeout, p_sel, p_en, p_wr}); end
    checks++; if ({rsp_rdata, p_addr, pw_data} !== 96'b0)
      begin errors++; $display("FAIL reset_data got=%h exp=0", {rsp_rdata, p_addr, pw_data}); end
    prst = 1'b1;
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    $display("txn reset released cmd_ready=%b", cmd_ready);
  endtask

  task automatic test_write();
    issue(1'b1, 32'h04, 32'hA5); p_ready = 1'b1;
    tick(); cmd_valid = 1'b0;
    checks++; if ({p_sel, p_en, p_wr, cmd_ready} !== 4'b1010)
      begin errors++; $display("FAIL wr_setup got=%b exp=1010", {p_sel, p_en, p_wr, cmd_ready}); end
    checks++; if (p_addr !== 32'h04 || pw_data !== 32'hA5)
      begin errors++; $display("FAIL wr_setup_bus got=%h/%h exp=00000004/000000a5", p_addr, pw_data); end
    tick();
    checks++; if ({p_sel, p_en, rsp_valid} !== 3'b110)
      begin errors++; $display("FAIL wr_access got=%b exp=110", {p_sel, p_en, rsp_valid}); end
    tick(); p_ready = 1'b0;
    checks++; if ({p_sel, p_en, rsp_valid, rsp_err, rsp_timeout} !== 5'b00100 || rsp_rdata !== 32'h0)
      begin errors++; $display("FAIL wr_rsp got=%b rdata=%h exp=00100 rdata=0", {p_sel, p_en, rsp_valid, rsp_err, rsp_timeout}, rsp_rdata); end
    checks++; if (p_addr !== 32'h04 || pw_data !== 32'hA5 || p_wr !== 1'b1)
      begin errors++; $display("FAIL wr_hold got=%h/%h/%b exp=00000004/000000a5/1", p_addr, pw_data, p_wr); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    checks++; if ({rsp_valid, cmd_ready} !== 2'b01)
      begin errors++; $display("FAIL wr_done got=%b exp=01", {rsp_valid, cmd_ready}); end
    $display("txn write addr=04 data=a5 err=%b", rsp_err);
  endtask

  task automatic test_read_wait();
    int n = 0;
    issue(1'b0, 32'h08, 32'h0); pr_data = 32'h5A; p_ready = 1'b0;
    tick(); cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 20 && p_sel; i++) begin
      if (p_sel && p_en) n++;
      if (n == 4) p_ready = 1'b1;
      tick();
    end
    p_ready = 1'b0;
    checks++; if (n !== 4) begin errors++; $display("FAIL rd_wait_cycles got=%0d exp=4", n); end
    checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100 || rsp_rdata !== 32'h5A)
      begin errors++; $display("FAIL rd_wait_rsp got=%b rdata=%h exp=100 rdata=5a", {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    $display("txn read addr=08 rdata=%h access_cycles=%0d", rsp_rdata, n);
  endtask

  task automatic test_slverr();
    issue(1'b0, 32'h0C, 32'h0); pr_data = 32'h0; p_ready = 1'b1; pslverr = 1'b1;
    tick(); cmd_valid = 1'b0;
    tick(); tick();
    p_ready = 1'b0; pslverr = 1'b0;
    checks++; if ({rsp_valid, rsp_err, rsp_timeout, p_sel} !== 4'b1100)
      begin errors++; $display("FAIL slverr_rsp got=%b exp=1100", {rsp_valid, rsp_err, rsp_timeout, p_sel}); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    $display("txn read addr=0c slverr err=%b", rsp_err);
  endtask

  task automatic test_timeout();
    int n = 0;
    issue(1'b0, 32'h10, 32'h0); pr_data = 32'hDEAD; p_ready = 1'b0;
    tick(); cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 40 && p_sel; i++) begin
      if (p_en) n++;
      tick();
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL timeout_cycles got=%0d exp=16", n); end
    checks++; if ({rsp_valid, rsp_err, rsp_timeout, p_en} !== 4'b1110 || rsp_rdata !== 32'h0)
      begin errors++; $display("FAIL timeout_rsp got=%b rdata=%h exp=1110 rdata=0", {rsp_valid, rsp_err, rsp_timeout, p_en}, rsp_rdata); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    $display("txn read addr=10 timeout after %0d access cycles", n);
  endtask

  task automatic test_misalign();
    issue(1'b1, 32'h02, 32'h77); p_ready = 1'b1;
    tick(); cmd_valid = 1'b0;
    checks++; if ({p_sel, rsp_valid, rsp_err, rsp_timeout} !== 4'b0110 || rsp_rdata !== 32'h0)
      begin errors++; $display("FAIL misalign_rsp got=%b rdata=%h exp=0110 rdata=0", {p_sel, rsp_valid, rsp_err, rsp_timeout}, rsp_rdata); end
    checks++; if (p_addr !== 32'h10 || p_wr !== 1'b0)
      begin errors++; $display("FAIL misalign_bus got=%h/%b exp=00000010/0", p_addr, p_wr); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0; p_ready = 1'b0;
    $display("txn write addr=02 misaligned err=%b", rsp_err);
  endtask

  task automatic test_back_to_back();
    int held = 0;
    issue(1'b1, 32'h20, 32'h1234); p_ready = 1'b1;
    tick(); tick(); tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_first_rsp got=%b exp=1", rsp_valid); end
    issue(1'b0, 32'h24, 32'h0); pr_data = 32'hCAFE;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_valid && !cmd_ready && !p_sel && !rsp_err) held++;
    end
    checks++; if (held !== 5) begin errors++; $display("FAIL b2b_held got=%0d exp=5", held); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    checks++; if ({rsp_valid, cmd_ready} !== 2'b01)
      begin errors++; $display("FAIL b2b_release got=%b exp=01", {rsp_valid, cmd_ready}); end
    $display("txn write addr=20 data=1234 held %0d cycles", held);
    tick(); cmd_valid = 1'b0;
    checks++; if ({p_sel, p_en, p_wr} !== 3'b100 || p_addr !== 32'h24)
      begin errors++; $display("FAIL b2b_second_setup got=%b addr=%h exp=100 addr=24", {p_sel, p_en, p_wr}, p_addr); end
    tick(); tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE)
      begin errors++; $display("FAIL b2b_second_rsp got=%b rdata=%h exp=1 rdata=cafe", rsp_valid, rsp_rdata); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0; p_ready = 1'b0;
    $display("txn read addr=24 rdata=%h", rsp_rdata);
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 32'h28, 32'h99); p_ready = 1'b0;
    tick(); cmd_valid = 1'b0;
    tick(); tick();
    checks++; if ({p_sel, p_en} !== 2'b11) begin errors++; $display("FAIL rstmid_access got=%b exp=11", {p_sel, p_en}); end
    #2 prst = 1'b0;
    #1;
    checks++; if ({cmd_ready, rsp_valid, rsp_err, rsp_timeout, p_sel, p_en, p_wr} !== 7'b0 || {p_addr, pw_data, rsp_rdata} !== 96'b0)
      begin errors++; $display("FAIL rstmid_outs got=%b exp=0000000", {cmd_ready, rsp_valid, rsp_err, rsp_timeout, p_sel, p_en, p_wr}); end
    tick(); prst = 1'b1;
    tick(); tick();
    checks++; if ({cmd_ready, rsp_valid, p_sel} !== 3'b100)
      begin errors++; $display("FAIL rstmid_recover got=%b exp=100", {cmd_ready, rsp_valid, p_sel}); end
    $display("txn write addr=28 aborted by reset");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
